// File: rtl/micro_seq_pkg.sv
// Shared encodings for the RV32I microprogram sequencer: next-state selects,
// major opcodes, microcode entry points and the ALUOP codes used by the ALU.
package micro_seq_pkg;

    typedef enum logic [2:0] {
        NS_NEXT     = 3'b000,
        NS_SPIN     = 3'b001,
        NS_JUMP     = 3'b010,
        NS_FETCH    = 3'b011,
        NS_DISPATCH = 3'b100,
        NS_EZ       = 3'b101,
        NS_ENZ      = 3'b110,
        NS_HALT     = 3'b111
    } next_sel_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [7:0] ENTRY_LUI    = 8'h10;
    localparam logic [7:0] ENTRY_AUIPC  = 8'h18;
    localparam logic [7:0] ENTRY_JAL    = 8'h20;
    localparam logic [7:0] ENTRY_JALR   = 8'h28;
    localparam logic [7:0] ENTRY_BRANCH = 8'h30;
    localparam logic [7:0] ENTRY_LOAD   = 8'h40;
    localparam logic [7:0] ENTRY_STORE  = 8'h50;
    localparam logic [7:0] ENTRY_OP_IMM = 8'h60;
    localparam logic [7:0] ENTRY_OP     = 8'h70;

    // Kept here so the microcode ROM image and the ALU decode from one source.
    typedef enum logic [3:0] {
        ALU_COPY_A = 4'd0,
        ALU_COPY_B = 4'd1,
        ALU_ADD    = 4'd2,
        ALU_SUB    = 4'd3,
        ALU_SLL    = 4'd4,
        ALU_SRL    = 4'd5,
        ALU_SLT    = 4'd6,
        ALU_XOR    = 4'd7,
        ALU_AND    = 4'd8,
        ALU_OR     = 4'd9
    } aluop_e;

endpackage

// File: rtl/micro_sequencer_dispatch_rom.sv
// Combinational opcode decode to microcode entry address; valid=0 flags an
// opcode with no microcode routine.
module dispatch_rom
    import micro_seq_pkg::*;
#(
    parameter int UPC_W = 8,
    parameter int OPC_W = 7
) (
    input  logic [OPC_W-1:0] opcode,
    output logic [UPC_W-1:0] entry,
    output logic             valid
);

    always_comb begin
        entry = '0;
        valid = 1'b1;
        case (opcode)
            OPC_W'(OPC_LUI):    entry = UPC_W'(ENTRY_LUI);
            OPC_W'(OPC_AUIPC):  entry = UPC_W'(ENTRY_AUIPC);
            OPC_W'(OPC_JAL):    entry = UPC_W'(ENTRY_JAL);
            OPC_W'(OPC_JALR):   entry = UPC_W'(ENTRY_JALR);
            OPC_W'(OPC_BRANCH): entry = UPC_W'(ENTRY_BRANCH);
            OPC_W'(OPC_LOAD):   entry = UPC_W'(ENTRY_LOAD);
            OPC_W'(OPC_STORE):  entry = UPC_W'(ENTRY_STORE);
            OPC_W'(OPC_OP_IMM): entry = UPC_W'(ENTRY_OP_IMM);
            OPC_W'(OPC_OP):     entry = UPC_W'(ENTRY_OP);
            default:            valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/micro_sequencer.sv
// Micro-PC sequencer: selects the next microcode address from the current
// microinstruction's next_sel field, with dispatch, micro-branches and halt.
module micro_sequencer
    import micro_seq_pkg::*;
#(
    parameter int               UPC_W      = 8,
    parameter int               OPC_W      = 7,
    parameter logic [UPC_W-1:0] FETCH_ADDR = '0,
    parameter logic [UPC_W-1:0] TRAP_ADDR  = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPC_W-1:0] opcode,
    input  logic             zero,
    input  logic             mem_busy,
    input  logic [2:0]       next_sel,
    input  logic [UPC_W-1:0] jump_target,
    output logic [UPC_W-1:0] upc,
    output logic             illegal,
    output logic             halted,
    output logic [31:0]      instr_cnt,
    output logic [31:0]      cycle_cnt
);

    logic [UPC_W-1:0] upc_q, upc_d;
    logic             illegal_q, illegal_d;
    logic             halted_q, halted_d;
    logic [31:0]      instr_cnt_q, instr_cnt_d;
    logic [31:0]      cycle_cnt_q, cycle_cnt_d;

    logic [UPC_W-1:0] upc_inc;
    logic [UPC_W-1:0] entry;
    logic             entry_valid;
    next_sel_e        sel;

    assign sel     = next_sel_e'(next_sel);
    assign upc_inc = upc_q + UPC_W'(1);

    dispatch_rom #(
        .UPC_W (UPC_W),
        .OPC_W (OPC_W)
    ) u_dispatch_rom (
        .opcode (opcode),
        .entry  (entry),
        .valid  (entry_valid)
    );

    always_comb begin
        upc_d       = upc_q;
        illegal_d   = illegal_q;
        halted_d    = halted_q;
        instr_cnt_d = instr_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        // Once halted, every microinstruction field is ignored until reset.
        if (!halted_q) begin
            cycle_cnt_d = cycle_cnt_q + 32'd1;
            case (sel)
                NS_NEXT:  upc_d = upc_inc;
                NS_SPIN:  upc_d = mem_busy ? upc_q : upc_inc;
                NS_JUMP:  upc_d = jump_target;
                NS_FETCH: upc_d = FETCH_ADDR;
                NS_DISPATCH: begin
                    instr_cnt_d = instr_cnt_q + 32'd1;
                    if (entry_valid) begin
                        upc_d = entry;
                    end else begin
                        upc_d     = TRAP_ADDR;
                        illegal_d = 1'b1;
                    end
                end
                NS_EZ:    upc_d = zero ? jump_target : upc_inc;
                NS_ENZ:   upc_d = zero ? upc_inc : jump_target;
                NS_HALT:  halted_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            upc_q       <= FETCH_ADDR;
            illegal_q   <= 1'b0;
            halted_q    <= 1'b0;
            instr_cnt_q <= '0;
            cycle_cnt_q <= '0;
        end else begin
            upc_q       <= upc_d;
            illegal_q   <= illegal_d;
            halted_q    <= halted_d;
            instr_cnt_q <= instr_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign upc       = upc_q;
    assign illegal   = illegal_q;
    assign halted    = halted_q;
    assign instr_cnt = instr_cnt_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: directed scenarios plus a random
// run, all compared against a behavioural model of the sequencing rules.
module tb_micro_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = '0;
    logic       zero = 1'b0;
    logic       mem_busy = 1'b0;
    logic [2:0] next_sel = 3'd0;
    logic [7:0] jump_target = '0;
    logic [7:0] upc;
    logic       illegal;
    logic       halted;
    logic [31:0] instr_cnt;
    logic [31:0] cycle_cnt;

    int checks = 0;
    int passes = 0;

    // Reference model state.
    int          m_upc;
    bit          m_ill;
    bit          m_halt;
    int unsigned m_instr;
    int unsigned m_cycle;
    int          entry_of[int];

    micro_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .zero        (zero),
        .mem_busy    (mem_busy),
        .next_sel    (next_sel),
        .jump_target (jump_target),
        .upc         (upc),
        .illegal     (illegal),
        .halted      (halted),
        .instr_cnt   (instr_cnt),
        .cycle_cnt   (cycle_cnt)
    );

    always #5 clk = ~clk;

    wire [73:0] dut_vec = {upc, illegal, halted, instr_cnt, cycle_cnt};

    function automatic logic [73:0] model_vec();
        return {8'(m_upc), m_ill, m_halt, m_instr, m_cycle};
    endfunction

    // Drive one microinstruction, clock it, and advance the model.
    task automatic cyc(input bit r, input bit [2:0] s, input bit [7:0] t,
                       input bit z, input bit b, input bit [6:0] o);
        rst = r; next_sel = s; jump_target = t; zero = z; mem_busy = b; opcode = o;
        @(posedge clk);
        if (r) begin
            m_upc = 0; m_ill = 0; m_halt = 0; m_instr = 0; m_cycle = 0;
        end else if (!m_halt) begin
            m_cycle++;
            case (s)
                3'd0: m_upc = (m_upc + 1) % 256;
                3'd1: if (!b) m_upc = (m_upc + 1) % 256;
                3'd2: m_upc = t;
                3'd3: m_upc = 0;
                3'd4: begin
                    m_instr++;
                    if (entry_of.exists(int'(o))) m_upc = entry_of[int'(o)];
                    else begin m_upc = 255; m_ill = 1; end
                end
                3'd5: m_upc = z ? int'(t) : (m_upc + 1) % 256;
                3'd6: m_upc = !z ? int'(t) : (m_upc + 1) % 256;
                default: m_halt = 1;
            endcase
        end
        #1;
    endtask

    task automatic test_reset();
        cyc(1, 3'd0, 8'h00, 0, 0, 7'h00);
        cyc(1, 3'd2, 8'h55, 1, 1, 7'h33);
        checks++;
        if (dut_vec !== 74'd0) $display("FAIL reset_state: got %h required %h", dut_vec, 74'd0);
        else passes++;
        for (int i = 1; i <= 3; i++) begin
            cyc(0, 3'd0, 8'hAA, 1, 1, 7'h00);
            checks++;
            if (upc !== 8'(i) || dut_vec !== model_vec())
                $display("FAIL next_%0d: got %h required upc=%h vec %h", i, dut_vec, 8'(i), model_vec());
            else passes++;
        end
    endtask

    task automatic test_spin();
        int unsigned c0;
        cyc(0, 3'd2, 8'h05, 0, 0, 7'h00);
        c0 = cycle_cnt;
        for (int i = 0; i < 4; i++) begin
            cyc(0, 3'd1, 8'h77, 1, 1, 7'h00);
            checks++;
            if (upc !== 8'h05 || dut_vec !== model_vec())
                $display("FAIL spin_hold: got upc=%h vec %h required upc=05 vec %h", upc, dut_vec, model_vec());
            else passes++;
        end
        cyc(0, 3'd1, 8'h77, 1, 0, 7'h00);
        checks++;
        if (upc !== 8'h06 || cycle_cnt - c0 !== 32'd5 || dut_vec !== model_vec())
            $display("FAIL spin_release: got upc=%h dcyc=%0d required upc=06 dcyc=5", upc, cycle_cnt - c0);
        else passes++;
        // Reset wins over a busy spin.
        cyc(1, 3'd1, 8'h00, 0, 1, 7'h00);
        checks++;
        if (dut_vec !== 74'd0) $display("FAIL reset_mid_spin: got %h required 0", dut_vec);
        else passes++;
    endtask

    task automatic test_dispatch();
        cyc(0, 3'd4, 8'h00, 0, 0, 7'b0110011);
        checks++;
        if (upc !== 8'h70 || instr_cnt !== 32'd1 || dut_vec !== model_vec())
            $display("FAIL dispatch_op: got upc=%h instr=%0d required upc=70 instr=1", upc, instr_cnt);
        else passes++;
        cyc(0, 3'd4, 8'h00, 1, 1, 7'b1100011);
        checks++;
        if (upc !== 8'h30 || instr_cnt !== 32'd2 || illegal !== 1'b0)
            $display("FAIL dispatch_branch: got upc=%h instr=%0d required upc=30 instr=2", upc, instr_cnt);
        else passes++;
        foreach (entry_of[k]) begin
            cyc(0, 3'd4, 8'h00, 0, 0, 7'(k));
            checks++;
            if (dut_vec !== model_vec())
                $display("FAIL dispatch_%h: got %h required %h", 7'(k), dut_vec, model_vec());
            else passes++;
        end
    endtask

    task automatic test_branch();
        bit [2:0] sel_t[3] = '{3'd5, 3'd5, 3'd6};
        bit       z_t[3]   = '{1, 0, 0};
        bit [7:0] exp_t[3] = '{8'h38, 8'h32, 8'h38};
        for (int i = 0; i < 3; i++) begin
            cyc(0, 3'd2, 8'h31, 0, 0, 7'h00);
            cyc(0, sel_t[i], 8'h38, z_t[i], 1, 7'h7F);
            checks++;
            if (upc !== exp_t[i] || dut_vec !== model_vec())
                $display("FAIL branch_%0d: got upc=%h required %h", i, upc, exp_t[i]);
            else passes++;
        end
        cyc(0, 3'd6, 8'h38, 1, 0, 7'h00);
        checks++;
        if (upc !== 8'h39) $display("FAIL enz_fallthru: got upc=%h required 39", upc);
        else passes++;
        cyc(0, 3'd3, 8'h44, 1, 1, 7'h00);
        checks++;
        if (upc !== 8'h00) $display("FAIL fetch: got upc=%h required 00", upc);
        else passes++;
    endtask

    task automatic test_illegal();
        cyc(0, 3'd4, 8'h00, 0, 0, 7'b1111111);
        checks++;
        if (upc !== 8'hFF || illegal !== 1'b1 || dut_vec !== model_vec())
            $display("FAIL illegal_trap: got upc=%h ill=%b required upc=FF ill=1", upc, illegal);
        else passes++;
        cyc(0, 3'd0, 8'h00, 0, 0, 7'h00);
        checks++;
        if (upc !== 8'h00 || illegal !== 1'b1 || dut_vec !== model_vec())
            $display("FAIL illegal_sticky_wrap: got upc=%h ill=%b required upc=00 ill=1", upc, illegal);
        else passes++;
    endtask

    task automatic test_halt();
        int unsigned c0, i0;
        cyc(0, 3'd2, 8'h12, 0, 0, 7'h00);
        c0 = cycle_cnt;
        i0 = instr_cnt;
        cyc(0, 3'd7, 8'h00, 0, 0, 7'h00);
        checks++;
        if (upc !== 8'h12 || halted !== 1'b1 || cycle_cnt !== c0 + 1)
            $display("FAIL halt_enter: got upc=%h halted=%b cyc=%0d required 12/1/%0d", upc, halted, cycle_cnt, c0 + 1);
        else passes++;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 3'(i % 5), 8'h66, 1, 0, 7'b0110011);
            checks++;
            if (upc !== 8'h12 || cycle_cnt !== c0 + 1 || instr_cnt !== i0 || dut_vec !== model_vec())
                $display("FAIL halt_frozen: got upc=%h cyc=%0d instr=%0d required 12/%0d/%0d", upc, cycle_cnt, instr_cnt, c0 + 1, i0);
            else passes++;
        end
        cyc(1, 3'd7, 8'h00, 0, 0, 7'h00);
        checks++;
        if (dut_vec !== 74'd0) $display("FAIL halt_reset: got %h required 0", dut_vec);
        else passes++;
    endtask

    task automatic test_random();
        bit [2:0] s;
        bit [6:0] o;
        bit       r;
        int       keys[$];
        foreach (entry_of[k]) keys.push_back(k);
        for (int n = 0; n < 400; n++) begin
            s = 3'($urandom_range(0, 7));
            if (s == 3'd7 && $urandom_range(0, 3) != 0) s = 3'd0;
            o = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'(keys[$urandom_range(0, keys.size() - 1)]);
            r = ($urandom_range(0, 39) == 0);
            cyc(r, s, 8'($urandom), 1'($urandom), 1'($urandom), o);
            checks++;
            if (dut_vec !== model_vec())
                $display("FAIL random_%0d: got %h required %h", n, dut_vec, model_vec());
            else passes++;
        end
    endtask

    initial begin
        entry_of[7'b0110111] = 8'h10;
        entry_of[7'b0010111] = 8'h18;
        entry_of[7'b1101111] = 8'h20;
        entry_of[7'b1100111] = 8'h28;
        entry_of[7'b1100011] = 8'h30;
        entry_of[7'b0000011] = 8'h40;
        entry_of[7'b0100011] = 8'h50;
        entry_of[7'b0010011] = 8'h60;
        entry_of[7'b0110011] = 8'h70;
        test_reset();
        test_spin();
        test_dispatch();
        test_branch();
        test_illegal();
        test_halt();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
